// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and imem.
// req/gnt issue handshake; rvalid returns words in request order.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// RV32I fetch stage: credit-limited sequential imem requests,
// in-order fetch queue, redirect flush with stale-response discard.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_f,
    input  logic                   redirect_e,
    input  logic [31:0]            pc_target_e,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            instr_f,
    output logic [31:0]            pc_f,
    output logic [31:0]            pc_plus4_f,
    output logic                   valid_f
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    fq_entry_t     fq [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] q_count;
    logic [CW-1:0] live_cnt;
    logic [CW-1:0] discard_cnt;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;

    logic [CW:0]   credits;
    logic [CW-1:0] live_n;
    logic [CW-1:0] discard_n;
    logic [CW-1:0] q_count_n;
    logic [31:0]   target;
    logic          grant;
    logic          drop;
    logic          rsp_ok;
    logic          push;
    logic          pop;
    logic          valid;
    logic          unused_tgt;

    assign unused_tgt = ^pc_target_e[1:0];
    assign target     = {pc_target_e[31:2], 2'b00};

    // Queued words plus every in-flight response must fit the queue.
    assign credits = {1'b0, live_cnt} + {1'b0, discard_cnt}
                   + {1'b0, q_count};

    assign imem.imem_req  = rst_n & ~redirect_e & (credits < DEPTH_W);
    assign imem.imem_addr = fetch_pc;

    assign grant  = imem.imem_req & imem.imem_gnt;
    assign drop   = imem.imem_rvalid & (discard_cnt != '0);
    assign rsp_ok = imem.imem_rvalid & (discard_cnt == '0)
                  & (live_cnt != '0);
    assign push   = rsp_ok & ~redirect_e;
    assign valid  = q_count != '0;
    assign pop    = valid & ~stall_f & ~redirect_e;

    always_comb begin
        live_n    = live_cnt;
        discard_n = discard_cnt;
        q_count_n = q_count;
        if (redirect_e) begin
            live_n    = '0;
            discard_n = discard_cnt + live_cnt - CW'(drop | rsp_ok);
            q_count_n = '0;
        end else begin
            live_n    = live_cnt + CW'(grant) - CW'(rsp_ok);
            discard_n = discard_cnt - CW'(drop);
            q_count_n = q_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= {RESET_PC[31:2], 2'b00};
            resp_pc     <= {RESET_PC[31:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            q_count     <= '0;
            live_cnt    <= '0;
            discard_cnt <= '0;
        end else begin
            q_count     <= q_count_n;
            live_cnt    <= live_n;
            discard_cnt <= discard_n;
            if (redirect_e) begin
                fetch_pc <= target;
                resp_pc  <= target;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (grant) fetch_pc <= fetch_pc + 32'd4;
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fq[wr_ptr] <= '{pc: resp_pc, instr: imem.imem_rdata};
    end

    assign valid_f    = valid;
    assign instr_f    = valid ? fq[rd_ptr].instr : NOP_INSTR;
    assign pc_f       = valid ? fq[rd_ptr].pc : 32'h0;
    assign pc_plus4_f = pc_f + 32'd4;
endmodule
